// File: rtl/neo_sequencer_if.sv
// ============================================================================
// neo_sequencer_if : sample-in, memory and psi-out bundle of the NEO sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface neo_sequencer_if #(
    parameter int N = 8,
    parameter int M = 8
);
    localparam int c_aw = $clog2(M) + 1;

    logic                   in_valid;
    logic signed [N-1:0]    in_data;
    logic                   in_ready;

    logic [c_aw-1:0]        waddr;
    logic signed [N-1:0]    wdata;
    logic                   mem_we;
    logic [c_aw-1:0]        raddr;
    logic signed [N-1:0]    rdata;

    logic                   out_valid;
    logic signed [2*N:0]    out_data;
    logic                   out_ready;
    logic [1:0]             fill;

    modport master (
        input  in_valid, in_data, rdata, out_ready,
        output in_ready, waddr, wdata, mem_we, raddr, out_valid, out_data, fill
    );

    modport slave (
        output in_valid, in_data, rdata, out_ready,
        input  in_ready, waddr, wdata, mem_we, raddr, out_valid, out_data, fill
    );
endinterface

`default_nettype wire

// File: rtl/neo_sequencer.sv
// ============================================================================
// neo_sequencer : circular-buffer sample writer and psi = x1^2 - x0*x2 sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module neo_sequencer #(
    parameter int N = 8,
    parameter int M = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    neo_sequencer_if.master bus
);
    localparam int c_aw = $clog2(M) + 1;
    localparam logic [c_aw-1:0] c_m    = c_aw'(M);
    localparam logic [c_aw-1:0] c_last = c_aw'(M - 1);
    localparam logic [c_aw-1:0] c_one  = c_aw'(1);
    localparam logic [c_aw-1:0] c_two  = c_aw'(2);
    localparam logic [c_aw-1:0] c_zero = '0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_RD_C = 3'd3,
        S_CALC = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_aw-1:0]        r_wptr;
    logic [c_aw-1:0]        r_a;
    logic [c_aw-1:0]        r_raddr;
    logic [c_aw-1:0]        w_raddr;
    logic [1:0]             r_fill;
    logic signed [N-1:0]    r_xa;
    logic signed [N-1:0]    r_xb;
    logic signed [2*N:0]    r_psi;
    logic signed [2*N:0]    w_psi;
    logic signed [2*N:0]    w_xa_e;
    logic signed [2*N:0]    w_xb_e;
    logic signed [2*N:0]    w_xc_e;
    logic                   w_idle;
    logic                   w_accept;
    logic                   w_we;

    function automatic logic [c_aw-1:0] sub_mod(input logic [c_aw-1:0] v,
                                                 input logic [c_aw-1:0] d);
        return (v >= d) ? (v - d) : (v + c_m - d);
    endfunction

    // Ready is forced low while reset is held, even though the state is IDLE.
    assign w_idle   = (r_state == S_IDLE) && rst_n;
    assign w_accept = w_idle && bus.in_valid;
    assign w_we     = w_accept && !clear;

    // Operands widened before multiplying so the difference is exact.
    assign w_xa_e = (2*N+1)'(r_xa);
    assign w_xb_e = (2*N+1)'(r_xb);
    assign w_xc_e = (2*N+1)'(bus.rdata);
    assign w_psi  = w_xb_e * w_xb_e - w_xa_e * w_xc_e;

    assign bus.in_ready  = w_idle;
    assign bus.mem_we    = w_we;
    assign bus.waddr     = w_we ? r_wptr : c_zero;
    assign bus.wdata     = w_we ? bus.in_data : '0;
    assign bus.raddr     = w_raddr;
    assign bus.out_valid = (r_state == S_OUT);
    assign bus.out_data  = r_psi;
    assign bus.fill      = r_fill;

    always_comb begin
        w_state_nxt = r_state;
        w_raddr     = r_raddr;
        case (r_state)
            S_IDLE: if (w_accept && (r_fill >= 2'd2)) w_state_nxt = S_RD_A;
            S_RD_A: begin
                w_raddr     = sub_mod(r_a, c_two);
                w_state_nxt = S_RD_B;
            end
            S_RD_B: begin
                w_raddr     = sub_mod(r_a, c_one);
                w_state_nxt = S_RD_C;
            end
            S_RD_C: begin
                w_raddr     = r_a;
                w_state_nxt = S_CALC;
            end
            S_CALC: w_state_nxt = S_OUT;
            S_OUT:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (clear) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wptr  <= c_zero;
            r_a     <= c_zero;
            r_raddr <= c_zero;
            r_fill  <= 2'd0;
            r_xa    <= '0;
            r_xb    <= '0;
            r_psi   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_raddr <= w_raddr;
            if (clear) begin
                r_wptr <= c_zero;
                r_fill <= 2'd0;
            end else if (w_accept) begin
                r_a    <= r_wptr;
                r_wptr <= (r_wptr == c_last) ? c_zero : (r_wptr + c_one);
                if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
            end
            if (r_state == S_RD_B) r_xa  <= bus.rdata;
            if (r_state == S_RD_C) r_xb  <= bus.rdata;
            if (r_state == S_CALC) r_psi <= w_psi;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_neo_sequencer.sv
// ============================================================================
// tb_neo_sequencer : directed self-checking bench for neo_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_neo_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    int err_cnt = 0;
    int chk_cnt = 0;
    int tb_w    = 0;
    int last_a  = 0;

    neo_sequencer_if #(.N(8), .M(8)) bus();

    neo_sequencer #(.N(8), .M(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read sample memory
    logic signed [7:0] mem [8];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.waddr[2:0]] <= bus.wdata;
        bus.rdata <= mem[bus.raddr[2:0]];
    end

    task automatic check_val(input string tag, input longint got, input longint exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input int v);
        int n = 0;
        while (!bus.in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("in_ready_wait", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(v);
        #1;
        check_val("waddr", bus.waddr, tb_w);
        check_val("wdata", bus.wdata, v);
        check_val("mem_we", bus.mem_we, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        last_a = tb_w;
        tb_w   = (tb_w + 1) % 8;
    endtask

    task automatic get_result(input string tag, input longint exp);
        int n = 0;
        int ra [3];
        while (!bus.out_valid && n < 20) begin
            if (n < 3) ra[n] = bus.raddr;
            @(posedge clk); #1;
            n++;
        end
        check_val({tag, "_lat"}, n, 4);
        check_val({tag, "_psi"}, bus.out_data, exp);
        check_val({tag, "_ra0"}, ra[0], (last_a + 6) % 8);
        check_val({tag, "_ra1"}, ra[1], (last_a + 7) % 8);
        check_val({tag, "_ra2"}, ra[2], last_a);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_val({tag, "_drop"}, bus.out_valid, 0);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check_val(tag, seen, 0);
    endtask

    initial begin
        logic signed [16:0] d0;
        int n;
        int bad_hold;
        int bad_rdy;
        int bad_we;

        bus.in_valid  = 1'b1;
        bus.in_data   = 8'sd55;
        bus.out_ready = 1'b0;

        // Reset: outputs held at zero even with in_valid asserted
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", bus.in_ready, 0);
        check_val("rst_mem_we", bus.mem_we, 0);
        check_val("rst_waddr", bus.waddr, 0);
        check_val("rst_wdata", bus.wdata, 0);
        check_val("rst_raddr", bus.raddr, 0);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_out_data", bus.out_data, 0);
        check_val("rst_fill", bus.fill, 0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check_val("rel_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;

        // Basic NEO: 3, 5, 2 then 4
        send(3);
        expect_quiet("basic_quiet1", 6);
        send(5);
        expect_quiet("basic_quiet2", 6);
        send(2);
        get_result("basic", 19);
        send(4);
        get_result("basic4", -16);
        check_val("fill_sat", bus.fill, 3);

        // Clear wins over a simultaneous sample
        bus.in_valid = 1'b1;
        bus.in_data  = 8'sd77;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        tb_w = 0;
        check_val("clr_fill", bus.fill, 0);

        // Extremes
        send(127);
        send(-128);
        send(127);
        get_result("ext_pos", 255);
        send(-128);
        get_result("ext_neg", -255);

        // Wrap-around: ten samples 1..10, eight results of 1
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        tb_w = 0;
        for (int i = 0; i < 10; i++) begin
            send(i + 1);
            if (i >= 2) get_result($sformatf("wrap%0d", i), 1);
        end

        // Backpressure: 9, 10, 11 -> 1, held for 20 cycles
        send(11);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("bp_lat", n, 4);
        d0 = bus.out_data;
        check_val("bp_psi", d0, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'sd99;
        bad_hold = 0; bad_rdy = 0; bad_we = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (!bus.out_valid || bus.out_data !== d0) bad_hold++;
            if (bus.in_ready) bad_rdy++;
            if (bus.mem_we) bad_we++;
        end
        check_val("bp_hold", bad_hold, 0);
        check_val("bp_in_ready", bad_rdy, 0);
        check_val("bp_mem_we", bad_we, 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_val("bp_drop", bus.out_valid, 0);
        check_val("bp_idle", bus.in_ready, 1);

        // Clear in RD_B abandons the result and drops history
        send(12);
        @(posedge clk); #1;
        check_val("rdb_raddr", bus.raddr, (last_a + 7) % 8);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        tb_w = 0;
        expect_quiet("clr_noresult", 8);
        check_val("clr_fill2", bus.fill, 0);
        check_val("clr_idle", bus.in_ready, 1);
        send(1);
        expect_quiet("clr_quiet1", 6);
        send(-3);
        expect_quiet("clr_quiet2", 6);
        send(2);
        get_result("post_clr", 7);

        // Async reset during CALC
        send(5);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", bus.out_valid, 0);
        check_val("arst_out_data", bus.out_data, 0);
        check_val("arst_in_ready", bus.in_ready, 0);
        check_val("arst_raddr", bus.raddr, 0);
        check_val("arst_fill", bus.fill, 0);
        #3;
        rst_n = 1'b1;
        tb_w = 0;
        @(posedge clk); #1;
        expect_quiet("arst_noresult", 8);
        check_val("arst_idle", bus.in_ready, 1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire

// File: doc/neo_sequencer.md
Name: neo_sequencer

Overview:
- Controller that sequences the NEO datapath around the shared sample Memory (M locations, N-bit signed).
- Accepts input samples over a valid/ready handshake and writes them into Memory as a circular buffer.
- After each new sample, once three samples exist, it reads x[k-2], x[k-1] and x[k] back and computes psi[k-1] = x[k-1]^2 - x[k-2]*x[k].
- Presents psi on a valid/ready result port.

Parameters:
- N, 8, sample width in bits (signed).
- M, 8, number of Memory locations; M >= 3 required.

Ports:
- Clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- clear  in  1  synchronous: drops all history, returns to IDLE.
- in_valid  in  1  input sample valid.
- in_data  in  N  input sample, signed.
- in_ready  out  1  sequencer can accept a sample.
- waddr  out  $clog2(M)+1  Memory write address (values 0..M-1, MSB 0).
- wdata  out  N  Memory write data.
- mem_we  out  1  Memory write enable.
- raddr  out  $clog2(M)+1  Memory read address.
- rdata  in  N  Memory read data; valid one cycle after raddr is presented.
- out_valid  out  1  psi result valid.
- out_data  out  2N+1  psi, signed.
- out_ready  in  1  consumer accepts result.
- fill  out  2  samples held, saturating at 3.

Behaviour:
- Reset (reset=0, async): state=IDLE, wptr=0, fill=0, in_ready=0 during reset.
  - All other outputs are 0 during reset: waddr, wdata, mem_we, raddr, out_valid, out_data.
  - Internal operand registers xa, xb, xc are cleared.
- Reset deasserting mid-sequence: the sequence is abandoned and no result is emitted.
- States: IDLE, RD_A, RD_B, RD_C, CALC, OUT.
- IDLE: in_ready=1. Accept = in_valid & in_ready.
  - On accept, drive mem_we=1, waddr=wptr and wdata=in_data combinationally; Memory writes at that edge.
  - Let a = old wptr. wptr <= (wptr==M-1) ? 0 : wptr+1. fill <= min(fill+1, 3).
  - If fill was >= 2 before the accept, go to RD_A with a latched; otherwise stay in IDLE.
- RD_A: raddr = (a-2) mod M.
- RD_B: raddr = (a-1) mod M; xa <= rdata.
- RD_C: raddr = a; xb <= rdata.
- CALC: out_data <= xb*xb - xa*rdata, full-precision signed, 2N+1 bits, no saturation or truncation. Then go to OUT.
- OUT: out_valid=1 and out_data held stable until out_ready=1.
  - On the cycle where out_valid & out_ready, go to IDLE; out_valid drops next cycle.
- in_ready=0 and mem_we=0 in every state except IDLE.
- raddr holds its last value when not in an RD state.
- Latency: accept at cycle 0 -> out_valid at cycle 5 (RD_A=1, RD_B=2, RD_C=3, CALC=4, OUT=5). Sustained throughput is 1 sample per 6 cycles.
- Read-after-write: the write completes at the accept edge, before any read of address a in RD_C. No bypass needed.
- Wrap: all address arithmetic is modulo M. At a=0 the reads are M-2, M-1, 0; at a=1 they are M-1, 0, 1.
- clear (sync) takes effect at the next edge and wins over everything, including an in_valid or an OUT handshake in the same cycle.
  - Any pending result is discarded and the simultaneous sample is dropped.
  - Effect: wptr=0, fill=0, out_valid=0, state=IDLE.
  - Memory contents are not erased; fill=0 guarantees stale data is never read.
- Backpressure: out_ready=0 holds OUT indefinitely; no sample is accepted meanwhile.
- in_data is sampled only on accept; in_data changes while in_ready=0 are ignored.

Test Plan:
- Reset/idle: hold reset=0, then release -> all outputs 0 and fill=0; in_ready=1 in the first cycle after release.
- Basic NEO (N=8): feed 3, 5, 2.
  - No result after the first two samples.
  - After the third: raddr sequence 0, 1, 2; out_data=19 at exactly 5 cycles after accept.
  - A further sample 4 -> out_data = 2*2 - 5*4 = -16.
- Extremes: feed 127, -128, 127 -> 16384 - 16129 = 255. Then feed -128 -> 127^2 - (-128)(-128) = -255. Both are sign-correct in 17 bits.
- Wrap-around (M=8): feed 10 samples x[i]=i+1 -> 8 results.
  - Each result: (i+1)^2 - i*(i+2) = 1.
  - Last read sequence: raddr 7, 0, 1; waddr wraps to 0 after 7.
- Backpressure: out_ready=0 for 20 cycles while in_valid=1 -> out_valid and out_data stable, in_ready=0, no Memory write. Then out_ready=1 -> one handshake, IDLE next cycle.
- Clear/reset mid-op:
  - Assert clear in RD_B -> no result emitted, fill=0; three new samples are needed before the next result.
  - Assert async reset in CALC -> outputs 0 immediately, without waiting for a clock edge.
